// File: rtl/acc_mult_signed_seq_pkg.sv
// acc_mult_pkg: shared types and sizing helpers for the iterative signed
// multiplier (acc_mult_signed_seq).
//   state_t     : controller states IDLE / RUN / DONE
//   calc_nl     : number of 2-bit digit layers for a WB-bit multiplier operand
//   calc_cnt_w  : layer counter width, never narrower than 1 bit
package acc_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nl(input int wb);
    return wb / 2;
  endfunction

  function automatic int calc_cnt_w(input int nl);
    return (nl < 2) ? 1 : $clog2(nl);
  endfunction

endpackage

// File: rtl/acc_mult_signed_seq_if.sv
// acc_mult_signed_seq_if: operand / product handshake bundle.
//   in_valid/in_ready/in_a/in_b : operand side (producer -> multiplier)
//   out_valid/out_ready/out_p   : product side (multiplier -> consumer)
//   busy                        : multiplier is in RUN or DONE
//   in_acc                      : accumulate request, present only when
//                                 ACC_MULT_MAC_EN is defined
//   slave  modport : the multiplier
//   master modport : the producer/consumer environment
interface acc_mult_signed_seq_if #(
  parameter int WA = 8,
  parameter int WB = 8
);
  localparam int WP = WA + WB;

  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] in_a;
  logic [WB-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [WP-1:0] out_p;
  logic          busy;
`ifdef ACC_MULT_MAC_EN
  logic          in_acc;

  modport slave (
    input  in_valid, in_a, in_b, in_acc, out_ready,
    output in_ready, out_valid, out_p, busy
  );
  modport master (
    output in_valid, in_a, in_b, in_acc, out_ready,
    input  in_ready, out_valid, out_p, busy
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );
`endif

endinterface

// File: rtl/acc_mult_signed_seq_layer.sv
// acc_layer_step: one combinational 2-bit digit layer.
//   i_a     : signed multiplicand (WA bits)
//   i_digit : 2-bit digit of the multiplier
//   i_last  : digit is the most-significant one (signed, -2..1),
//             otherwise unsigned (0..3)
//   o_pp    : signed partial product i_a * digit (WA+2 bits)
module acc_layer_step #(
  parameter int WA = 8
) (
  input  logic [WA-1:0]        i_a,
  input  logic [1:0]           i_digit,
  input  logic                 i_last,
  output logic signed [WA+1:0] o_pp
);

  logic signed [2:0]    w_d;
  logic signed [WA+1:0] w_a_ext;
  logic signed [WA+1:0] w_d_ext;

  // |a*d| <= 3*2^(WA-1) fits in WA+2 signed bits, so the truncated product is exact.
  assign w_d     = i_last ? {i_digit[1], i_digit} : {1'b0, i_digit};
  assign w_a_ext = (WA+2)'($signed(i_a));
  assign w_d_ext = (WA+2)'(w_d);
  assign o_pp    = w_a_ext * w_d_ext;

endmodule

// File: rtl/acc_mult_signed_seq.sv
// acc_mult_signed_seq: iterative two's-complement multiplier, one 2-bit digit
// layer of B per clock, accumulated into a WA+WB product register.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : acc_mult_signed_seq_if.slave (operand and product handshakes, busy)
// Optional build macro ACC_MULT_MAC_EN: adds bus.in_acc; when set at accept
// the product register starts from the previous result (multiply-accumulate,
// wrapping modulo 2^WP).
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one digit layer accumulated per clock, NL clocks
// DONE  | product presented, held until out_ready
module acc_mult_signed_seq
  import acc_mult_pkg::*;
#(
  parameter int WA = 8,
  parameter int WB = 8
) (
  input logic                  clk,
  input logic                  rst,
  acc_mult_signed_seq_if.slave bus
);

  localparam int WP = WA + WB;
  localparam int NL = calc_nl(WB);
  localparam int CW = calc_cnt_w(NL);

  state_t r_state;
  state_t w_state_nxt;

  logic [WA-1:0] r_a;
  logic [WB-1:0] r_b;
  logic [CW-1:0] r_cnt;
  logic [WP-1:0] r_p;

  logic                 w_accept;
  logic                 w_last;
  logic [1:0]           w_digit;
  logic [CW:0]          w_shamt;
  logic signed [WA+1:0] w_pp;
  logic signed [WP-1:0] w_pp_ext;
  logic [WP-1:0]        w_layer;
  logic [WP-1:0]        w_p_init;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == CW'(NL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_digit = 2'b00;
    for (int i = 0; i < NL; i++) begin
      if (r_cnt == CW'(i)) w_digit = r_b[2*i +: 2];
    end
  end

  acc_layer_step #(.WA(WA)) u_layer (
    .i_a     (r_a),
    .i_digit (w_digit),
    .i_last  (w_last),
    .o_pp    (w_pp)
  );

  assign w_shamt  = {r_cnt, 1'b0};
  assign w_pp_ext = WP'(w_pp);
  assign w_layer  = w_pp_ext << w_shamt;

`ifdef ACC_MULT_MAC_EN
  // r_p still holds the last delivered product while idle.
  assign w_p_init = bus.in_acc ? r_p : '0;
`else
  assign w_p_init = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else if (w_accept) begin
      r_a   <= bus.in_a;
      r_b   <= bus.in_b;
      r_cnt <= '0;
      r_p   <= w_p_init;
    end else if (r_state == RUN) begin
      r_p   <= r_p + w_layer;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.out_p = r_p;

endmodule

// File: tb/tb_acc_mult_signed_seq.sv
module tb_acc_mult_signed_seq;

  localparam int WA = 8;
  localparam int WB = 8;
  localparam int WP = WA + WB;
  localparam int NL = WB / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_mult_signed_seq_if #(.WA(WA), .WB(WB)) bus ();

  acc_mult_signed_seq #(.WA(WA), .WB(WB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [WP-1:0] model_last = '0;

  // Reference: exact signed product, optionally added to the previous result.
  function automatic logic [WP-1:0] model_op(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                             input bit acc, input logic [WP-1:0] prev);
    int sa, sb, p;
    logic [WP-1:0] r;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    r  = p[WP-1:0];
    if (acc) r = r + prev;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input bit acc);
`ifdef ACC_MULT_MAC_EN
    bus.in_acc = acc;
`else
    if (acc) $display("note: accumulate ignored in this build");
`endif
  endtask

  task automatic do_accept(input logic [WA-1:0] a, input logic [WB-1:0] b, input bit acc);
    int w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    set_acc(acc);
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = WA'($urandom);
    bus.in_b     = WB'($urandom);
`ifdef ACC_MULT_MAC_EN
    bus.in_acc   = 1'($urandom);
`endif
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    ok = bus.out_valid;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input bit acc,
                        output logic [WP-1:0] p, output int lat, output bit ok);
    do_accept(a, b, acc);
    wait_valid(lat, ok);
    p = bus.out_p;
    consume();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_p !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b p=%h busy=%b required rdy=1 vld=0 p=0 busy=0",
               bus.in_ready, bus.out_valid, bus.out_p, bus.busy);
    end
    tick();
    tick();
    rst = 1'b0;
    model_last = '0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b vld=%b busy=%b", bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_directed();
    logic [WA-1:0] ta [4];
    logic [WB-1:0] tb [4];
    logic [WP-1:0] te [4];
    logic [WP-1:0] p;
    int lat;
    bit ok;
    ta = '{8'd7, 8'h80, 8'd127, 8'hFF};
    tb = '{8'd5, 8'h80, 8'h80,  8'd1};
    te = '{16'd35, 16'd16384, 16'hC080, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], 1'b0, p, lat, ok);
      model_last = te[i];
      checks++;
      if (!ok || lat != NL) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d cycles (valid=%b) required %0d", i, lat, ok, NL);
      end
      checks++;
      if (p !== te[i]) begin
        errors++;
        $display("FAIL directed_product[%0d]: %h*%h got %h required %h", i, ta[i], tb[i], p, te[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [WP-1:0] p, exp;
    bit acc, ok;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = WA'($urandom);
      b = WB'($urandom);
      if (i == 0) a = 8'h80;
      if (i == 1) b = 8'h7F;
`ifdef ACC_MULT_MAC_EN
      acc = 1'($urandom);
`else
      acc = 1'b0;
`endif
      exp = model_op(a, b, acc, model_last);
      run_op(a, b, acc, p, lat, ok);
      model_last = exp;
      checks++;
      if (!ok || p !== exp) begin
        errors++;
        $display("FAIL random[%0d]: %h*%h acc=%b got %h (valid=%b) required %h", i, a, b, acc, p, ok, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [WP-1:0] exp;
    int lat;
    bit ok;
    a = WA'($urandom);
    b = WB'($urandom);
    exp = model_op(a, b, 1'b0, model_last);
    do_accept(a, b, 1'b0);
    wait_valid(lat, ok);
    model_last = exp;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_valid: out_valid never rose, required 1");
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_p !== exp || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b p=%h rdy=%b required vld=1 p=%h rdy=0",
                 i, bus.out_valid, bus.out_p, bus.in_ready, exp);
      end
    end
    consume();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b busy=%b required vld=0 rdy=1 busy=0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_ignore_inflight();
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [WP-1:0] exp;
    int lat;
    bit ok;
    a = 8'hE9;
    b = 8'h5A;
    exp = model_op(a, b, 1'b0, model_last);
    do_accept(a, b, 1'b0);
    bus.in_a     = 8'd3;
    bus.in_b     = 8'd3;
    bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_ready: rdy=%b busy=%b required rdy=0 busy=1", bus.in_ready, bus.busy);
    end
    wait_valid(lat, ok);
    bus.in_valid = 1'b0;
    model_last = exp;
    checks++;
    if (!ok || lat != NL || bus.out_p !== exp) begin
      errors++;
      $display("FAIL ignore_product: got %h after %0d cycles required %h after %0d", bus.out_p, lat, exp, NL);
    end
    consume();
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_p !== exp) begin
      errors++;
      $display("FAIL ignore_no_second: vld=%b busy=%b p=%h required vld=0 busy=0 p=%h",
               bus.out_valid, bus.busy, bus.out_p, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [WP-1:0] p;
    int lat;
    bit ok;
    do_accept(8'h9C, 8'h37, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_p !== '0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_run: vld=%b p=%h busy=%b rdy=%b required 0/0/0/1",
               bus.out_valid, bus.out_p, bus.busy, bus.in_ready);
    end
    tick();
    rst = 1'b0;
    model_last = '0;
    do_accept(8'h85, 8'h7B, 1'b0);
    wait_valid(lat, ok);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_p !== '0) begin
      errors++;
      $display("FAIL reset_in_done: vld=%b p=%h required vld=0 p=0 (reached done=%b)",
               bus.out_valid, bus.out_p, ok);
    end
    tick();
    rst = 1'b0;
    run_op(8'd2, 8'd3, 1'b0, p, lat, ok);
    model_last = 16'd6;
    checks++;
    if (!ok || p !== 16'd6) begin
      errors++;
      $display("FAIL reset_recover: got %h (valid=%b) required 0006", p, ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [WP-1:0] exp_q[$];
    int hs_cyc[$];
    int sent = 0;
    logic [WP-1:0] e;
    bus.out_ready = 1'b1;
    set_acc(1'b0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.out_valid) begin
        hs_cyc.push_back(cyc);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        model_last = e;
        checks++;
        if (bus.out_p !== e) begin
          errors++;
          $display("FAIL b2b_product[%0d]: got %h required %h", hs_cyc.size() - 1, bus.out_p, e);
        end
      end
      if (bus.in_ready) begin
        if (sent < 4) begin
          bus.in_a     = WA'($urandom);
          bus.in_b     = WB'($urandom);
          bus.in_valid = 1'b1;
          exp_q.push_back(model_op(bus.in_a, bus.in_b, 1'b0, '0));
          sent++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (hs_cyc.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d products required 4", hs_cyc.size());
    end
    for (int i = 1; i < hs_cyc.size(); i++) begin
      checks++;
      if (hs_cyc[i] - hs_cyc[i-1] != NL + 2) begin
        errors++;
        $display("FAIL b2b_interval[%0d]: got %0d cycles required %0d", i, hs_cyc[i] - hs_cyc[i-1], NL + 2);
      end
    end
  endtask

`ifdef ACC_MULT_MAC_EN
  task automatic test_mac();
    logic [WA-1:0] ta [3];
    logic [WB-1:0] tb [3];
    bit            tc [3];
    logic [WP-1:0] te [3];
    logic [WP-1:0] p;
    int lat;
    bit ok;
    ta = '{8'd3, 8'd2, 8'd1};
    tb = '{8'd4, 8'd5, 8'd1};
    tc = '{1'b0, 1'b1, 1'b0};
    te = '{16'd12, 16'd22, 16'd1};
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], tc[i], p, lat, ok);
      model_last = te[i];
      checks++;
      if (!ok || p !== te[i]) begin
        errors++;
        $display("FAIL mac[%0d]: got %h (valid=%b) required %h", i, p, ok, te[i]);
      end
    end
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
`ifdef ACC_MULT_MAC_EN
    bus.in_acc    = 1'b0;
`endif
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_inflight();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef ACC_MULT_MAC_EN
    test_mac();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
